// File: rtl/imm_gen_pipe_pkg.sv
// rtl/imm_gen_pipe_pkg.sv - shared immediate format encodings for the ID-stage immediate pipeline
package imm_gen_pipe_pkg;

    // Immediate format select codes driven by the decoder
    typedef enum logic [2:0] {
        I_TYPE     = 3'b000,
        S_TYPE     = 3'b001,
        B_TYPE     = 3'b010,
        U_TYPE     = 3'b011,
        J_TYPE     = 3'b100,
        SHAMT_TYPE = 3'b101,
        ZIMM_TYPE  = 3'b110,
        ILL_TYPE   = 3'b111
    } imm_sel_e;

    // Width of the instruction slice carried on the imm port: instr[31:7]
    localparam int unsigned IMM_IN_W = 25;

    // Width of the shift-amount field for a given datapath width
    function automatic int unsigned shamt_width(input int unsigned xlen);
        return (xlen == 64) ? 6 : 5;
    endfunction

endpackage

// File: rtl/imm_extend_xlen.sv
// rtl/imm_extend_xlen.sv - combinational immediate extractor/extender for XLEN 32 or 64
module imm_extend_xlen
    import imm_gen_pipe_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [IMM_IN_W-1:0] imm,
    input  logic [2:0]          imm_sel,
    output logic [XLEN-1:0]     imm_ext,
    output logic                imm_illegal
);

    localparam int unsigned SHW = shamt_width(XLEN);

    // imm[k] carries instr[k+7]; each format gathers its fields and sign/zero extends to XLEN
    logic [11:0] i_field;
    logic [11:0] s_field;
    logic [12:0] b_field;
    logic [31:0] u_field;
    logic [20:0] j_field;

    assign i_field = imm[24:13];
    assign s_field = {imm[24:18], imm[4:0]};
    assign b_field = {imm[24], imm[0], imm[23:18], imm[4:1], 1'b0};
    assign u_field = {imm[24:5], 12'b0};
    assign j_field = {imm[24], imm[12:5], imm[13], imm[23:14], 1'b0};

    // Format select: sign-extended formats use instr[31] as sign, SHAMT/ZIMM zero-extend
    always_comb begin
        imm_ext     = '0;
        imm_illegal = 1'b0;
        case (imm_sel_e'(imm_sel))
            I_TYPE:     imm_ext = XLEN'($signed(i_field));
            S_TYPE:     imm_ext = XLEN'($signed(s_field));
            B_TYPE:     imm_ext = XLEN'($signed(b_field));
            U_TYPE:     imm_ext = XLEN'($signed(u_field));
            J_TYPE:     imm_ext = XLEN'($signed(j_field));
            SHAMT_TYPE: imm_ext = XLEN'(imm[13 +: SHW]);
            ZIMM_TYPE:  imm_ext = XLEN'(imm[12:8]);
            ILL_TYPE:   imm_illegal = 1'b1;
            default:    imm_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined immediate generator with a 2-entry skid buffer
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [IMM_IN_W-1:0] imm,
    input  logic [2:0]          imm_sel,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     imm_ext,
    output logic                imm_illegal
);

    if (DEPTH != 2) begin : g_depth_chk
        $error("imm_gen_pipe: DEPTH must be 2");
    end
    if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] new_ext;
    logic            new_ill;

    // The head entry is its own register so that imm_ext keeps the last
    // popped value while the buffer is empty; the second entry only ever
    // feeds the head.
    logic [XLEN-1:0] head_ext;
    logic            head_ill;
    logic [XLEN-1:0] second_ext;
    logic            second_ill;
    logic [1:0]      count;

    logic accept;
    logic pop;

    imm_extend_xlen #(
        .XLEN (XLEN)
    ) u_extend (
        .imm         (imm),
        .imm_sel     (imm_sel),
        .imm_ext     (new_ext),
        .imm_illegal (new_ill)
    );

    // Handshake flags come from the count register only, so in_ready has no path from out_ready
    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign imm_ext     = head_ext;
    assign imm_illegal = head_ill;

    // Buffer update: reset beats flush, flush discards any same-cycle accept/pop
    always_ff @(posedge CLK) begin
        if (RESET) begin
            count      <= 2'd0;
            head_ext   <= '0;
            head_ill   <= 1'b0;
            second_ext <= '0;
            second_ill <= 1'b0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case (count)
                2'd0: begin
                    if (accept) begin
                        head_ext <= new_ext;
                        head_ill <= new_ill;
                        count    <= 2'd1;
                    end
                end
                2'd1: begin
                    if (accept && pop) begin
                        head_ext <= new_ext;
                        head_ill <= new_ill;
                    end else if (accept) begin
                        second_ext <= new_ext;
                        second_ill <= new_ill;
                        count      <= 2'd2;
                    end else if (pop) begin
                        count <= 2'd0;
                    end
                end
                default: begin
                    if (pop) begin
                        head_ext <= second_ext;
                        head_ill <= second_ill;
                        count    <= 2'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the ID stage; successor to the combinational ID-stage immediate extender.
- Generalised to XLEN 32/64. Adds two modes: SHAMT (shift amount) and ZIMM (CSR zero-extended immediate), plus an illegal-select flag.
- Decouples decode from the ID/EX register through a 2-entry skid buffer with valid/ready handshake and a flush input.
- Latency is one cycle from accept to output.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- DEPTH, 2, skid buffer entries; fixed at 2 and checked by an elaboration-time assertion.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- imm  in  25  instruction bits [31:7]; imm[k] = instr[k+7].
- imm_sel  in  3  immediate format select.
- in_valid  in  1  input word valid.
- in_ready  out  1  buffer can accept a word.
- flush  in  1  discard all buffered words (branch/jump redirect).
- out_valid  out  1  imm_ext is valid.
- out_ready  in  1  consumer accepts the output.
- imm_ext  out  XLEN  extended immediate.
- imm_illegal  out  1  the word at the head was accepted with imm_sel = 111.

Behaviour:
- Format map (sign bit is instr[31] = imm[24], replicated to XLEN):
  - 000 I: sext(instr[31:20]).
  - 001 S: sext({instr[31:25], instr[11:7]}).
  - 010 B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 011 U: sext({instr[31:12], 12'b0}); for XLEN=64, bits 63:32 copy bit 31.
  - 100 J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 101 SHAMT: zext(instr[24:20]) when XLEN=32; zext(instr[25:20]) when XLEN=64.
  - 110 ZIMM: zext(instr[19:15]).
  - 111: imm_ext = 0 and imm_illegal = 1 for that entry.
- Extension is combinational on the input side. Each entry stores {imm_ext, imm_illegal}, so the outputs come straight from flops.
- Occupancy count is 0..2.
  - in_ready = (count < 2), driven from registered state only, with no combinational path from out_ready.
  - out_valid = (count > 0).
- Accept when in_valid & in_ready. Pop when out_valid & out_ready. Both may happen in the same cycle: count is unchanged and order is preserved.
- Latency: a word accepted in cycle N appears with out_valid = 1 in cycle N+1 if the buffer was empty.
- Ordering is strict FIFO. The head entry drives imm_ext and imm_illegal. When the head pops with count = 2, the second entry becomes head in the next cycle.
- Full (count = 2): in_ready = 0; in_valid is ignored and does not corrupt state.
- Empty (count = 0): imm_ext and imm_illegal hold their last value; consumers qualify them with out_valid.
- Flush (synchronous): next cycle count = 0 and out_valid = 0. Any accept or pop in the flush cycle is discarded. in_ready = 1 from the next cycle.
- Reset (synchronous, same effect at any point, including mid-transfer):
  - count = 0, out_valid = 0, in_ready = 1.
  - imm_ext = 0, imm_illegal = 0, both entry storages cleared.
- Precedence: RESET over flush over accept/pop.
- Pointer implementation: 1-bit read and write pointers wrap modulo 2. Alternatively, a shift implementation is allowed if behaviour is identical at the ports.

Decomposition:
- Shared encodings include: add SHAMT_TYPE = 3'b101 and ZIMM_TYPE = 3'b110 alongside the existing I/S/B/U/J codes (000/001/010/011/100). All stages use these names.
- One sub-module, imm_extend_xlen: combinational, parametrised by XLEN, implements the format map and the illegal flag.
- imm_gen_pipe instantiates imm_extend_xlen and owns the skid buffer, count, and control.

Test Plan:
- XLEN=32, out_ready=1. Send each of the following with in_valid for one cycle; each must appear one cycle later with out_valid=1:
  - I, instr 0xFFF00093 -> 0xFFFFFFFF.
  - S, 0xFE20AE23 -> 0xFFFFFFFC.
  - B, 0xFE000CE3 -> 0xFFFFFFF8.
  - U, 0x123450B7 -> 0x12345000.
  - J, 0xFFDFF0EF -> 0xFFFFFFFC.
  - ZIMM, instr with [19:15] = 0x1F -> 0x0000001F.
- XLEN=64:
  - SHAMT, instr[25:20] = 0x3F -> 0x000000000000003F.
  - U, 0x800000B7 -> 0xFFFFFFFF80000000.
- Backpressure: out_ready=0, offer three I words with values 1, 2, 3.
  - Values 1 and 2 are accepted; in_ready=0 while value 3 is held.
  - Raise out_ready: outputs 1, 2, 3 in order with no loss or duplication.
- Simultaneous push and pop at count=1 for 10 cycles: count stays 1 and the output stream equals the input stream delayed by one cycle.
- Flush with count=2 while in_valid=1: next cycle out_valid=0 and in_ready=1, and the flushed and offered words never appear.
- Select 111: imm_ext=0 and imm_illegal=1 at the head. RESET asserted with count=2 mid-transfer: next cycle all outputs are at their reset values.
